// File: rtl/layer_0_pool_if.sv
// Layer-0 pooling stream bundle.
// Carries the layer-0 read-side inputs into the 2x2 max-pool stage and the
// pooled result stream out of it.
//   rdy_in       : layer-0 window-ready (a full 2x2 window is readable)
//   din_0/din_1  : layer-0 RAM read data, channels 0/1
//   dout_vld     : one-cycle pulse, new pooled result present
//   dout_0/1     : pooled maxima per channel
//   dout_idx     : row-major window index of the shown result
//   frame_done   : pulse with the last window of a frame
//   bsy          : pool stage is consuming a window
// master = producer/consumer environment, slave = the pool stage.
`timescale 1ns/1ps
interface layer_0_pool_if #(
    parameter int unsigned DW = 18,
    parameter int unsigned IW = 8
);
    logic          rdy_in;
    logic [DW-1:0] din_0;
    logic [DW-1:0] din_1;
    logic          dout_vld;
    logic [DW-1:0] dout_0;
    logic [DW-1:0] dout_1;
    logic [IW-1:0] dout_idx;
    logic          frame_done;
    logic          bsy;

    modport master (
        output rdy_in, din_0, din_1,
        input  dout_vld, dout_0, dout_1, dout_idx, frame_done, bsy
    );

    modport slave (
        input  rdy_in, din_0, din_1,
        output dout_vld, dout_0, dout_1, dout_idx, frame_done, bsy
    );
endinterface

// File: rtl/layer_0_pool.sv
// 2x2 max-pool stage on the layer-0 feature RAM read port.
// Accepts a window when rdy_in is seen in IDLE, takes the four window words
// on the next four cycles (C0..C3), and registers the per-channel maximum
// one cycle later together with its window index. After the last window of
// the frame the stage parks in DONE until tx_done.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   tx_done : synchronous frame abort/restart strobe
//   bus     : layer_0_pool_if.slave (rdy_in, din_*, dout_*, frame_done, bsy)
`timescale 1ns/1ps
module layer_0_pool #(
    parameter int unsigned DW    = 18,
    parameter int unsigned N_WIN = 169,
    parameter int unsigned IW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tx_done,
    layer_0_pool_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_C0,
        S_C1,
        S_C2,
        S_C3,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [DW-1:0] r_max0;
    logic [DW-1:0] r_max1;
    logic [IW-1:0] r_cnt;

    logic          r_vld;
    logic [DW-1:0] r_dout0;
    logic [DW-1:0] r_dout1;
    logic [IW-1:0] r_idx;
    logic          r_fdone;

    logic [DW-1:0] w_max0;
    logic [DW-1:0] w_max1;
    logic          w_last;

    // Strictly-greater compare: ties keep the held value.
    assign w_max0 = (bus.din_0 > r_max0) ? bus.din_0 : r_max0;
    assign w_max1 = (bus.din_1 > r_max1) ? bus.din_1 : r_max1;
    assign w_last = (r_cnt == IW'(N_WIN - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; tx_done overrides every transition.
    always_comb begin
        w_next = r_state;
        if (tx_done) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.rdy_in) w_next = S_C0;
                S_C0:    w_next = S_C1;
                S_C1:    w_next = S_C2;
                S_C2:    w_next = S_C3;
                S_C3:    w_next = w_last ? S_DONE : S_IDLE;
                S_DONE:  w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Datapath: running max, window counter, registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max0  <= '0;
            r_max1  <= '0;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
            r_dout0 <= '0;
            r_dout1 <= '0;
            r_idx   <= '0;
            r_fdone <= 1'b0;
        end else if (tx_done) begin
            // Result registers deliberately keep their last value.
            r_max0  <= '0;
            r_max1  <= '0;
            r_cnt   <= '0;
            r_vld   <= 1'b0;
            r_fdone <= 1'b0;
        end else begin
            r_vld   <= 1'b0;
            r_fdone <= 1'b0;
            case (r_state)
                S_C0: begin
                    // First word loads directly; no compare against the previous window.
                    r_max0 <= bus.din_0;
                    r_max1 <= bus.din_1;
                end
                S_C1, S_C2: begin
                    r_max0 <= w_max0;
                    r_max1 <= w_max1;
                end
                S_C3: begin
                    r_dout0 <= w_max0;
                    r_dout1 <= w_max1;
                    r_idx   <= r_cnt;
                    r_vld   <= 1'b1;
                    if (w_last) begin
                        r_fdone <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dout_vld   = r_vld;
    assign bus.dout_0     = r_dout0;
    assign bus.dout_1     = r_dout1;
    assign bus.dout_idx   = r_idx;
    assign bus.frame_done = r_fdone;
    assign bus.bsy        = (r_state == S_C0) || (r_state == S_C1) ||
                            (r_state == S_C2) || (r_state == S_C3);

endmodule

// File: tb/tb_layer_0_pool.sv
// Self-checking bench for layer_0_pool: fixed vector table, random windows
// against a max-of-four reference, full-frame streaming, reset and abort
// sequences.
`timescale 1ns/1ps
module tb_layer_0_pool;

    localparam int unsigned DW    = 18;
    localparam int unsigned N_WIN = 169;
    localparam int unsigned IW    = 8;

    typedef logic [3:0][DW-1:0] win_t;

    typedef struct {
        win_t          w0;
        win_t          w1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic tx_done = 1'b0;

    layer_0_pool_if #(.DW(DW), .IW(IW)) bus ();

    layer_0_pool #(.DW(DW), .N_WIN(N_WIN), .IW(IW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_done (tx_done),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int errors  = 0;
    int checks  = 0;
    int exp_idx = 0;

    logic [DW-1:0] last0, last1;

    int mon_en  = 0;
    int vld_cnt = 0;
    int fd_cnt  = 0;

    always @(negedge clk) begin
        if (mon_en != 0) begin
            if (bus.dout_vld)   vld_cnt++;
            if (bus.frame_done) fd_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic win_t pk(input int unsigned a, input int unsigned b,
                                input int unsigned c, input int unsigned d);
        win_t r;
        r[0] = DW'(a);
        r[1] = DW'(b);
        r[2] = DW'(c);
        r[3] = DW'(d);
        return r;
    endfunction

    // Reference: the pooled value is simply the largest of the four words.
    function automatic logic [DW-1:0] ref_max(input win_t w);
        int unsigned m = 0;
        for (int i = 0; i < 4; i++)
            if (int'(w[i]) > int'(m)) m = w[i];
        return DW'(m);
    endfunction

    // Called away from a rising edge with the DUT in IDLE; ends on a falling edge.
    task automatic run_window(input win_t w0, input win_t w1,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        bus.rdy_in = 1'b1;
        @(posedge clk);
        #1 bus.rdy_in = 1'b0;
        for (int j = 0; j < 4; j++) begin
            bus.din_0 = w0[j];
            bus.din_1 = w1[j];
            if (j == 1) begin
                @(negedge clk);
                chk("bsy_in_window", 32'(bus.bsy), 32'd1);
            end
            if (j < 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("dout_vld",   32'(bus.dout_vld),   32'd1);
        chk("dout_0",     32'(bus.dout_0),     32'(e0));
        chk("dout_1",     32'(bus.dout_1),     32'(e1));
        chk("dout_idx",   32'(bus.dout_idx),   32'(exp_idx));
        chk("frame_done", 32'(bus.frame_done), 32'(exp_idx == int'(N_WIN) - 1));
        last0   = e0;
        last1   = e1;
        exp_idx = (exp_idx + 1) % int'(N_WIN);
        @(posedge clk);
        @(negedge clk);
        chk("dout_vld_pulse_end", 32'(bus.dout_vld), 32'd0);
        chk("dout_0_hold",        32'(bus.dout_0),   32'(e0));
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        exp_idx = 0;
        @(negedge clk);
    endtask

    vec_t tbl [6];
    logic [DW-1:0] m0 [N_WIN][4];
    logic [DW-1:0] m1 [N_WIN][4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        win_t a, b;
        int   nv;

        bus.rdy_in = 1'b0;
        bus.din_0  = '0;
        bus.din_1  = '0;

        tbl[0] = '{w0: pk(5, 9, 3, 7),       w1: pk(0, 0, 'h3FFFF, 1),             e0: 18'd9,       e1: 18'h3FFFF};
        tbl[1] = '{w0: pk(100, 50, 100, 20), w1: pk(100, 100, 100, 100),          e0: 18'd100,     e1: 18'd100};
        tbl[2] = '{w0: pk(1, 2, 3, 4),       w1: pk(4, 3, 2, 1),                   e0: 18'd4,       e1: 18'd4};
        tbl[3] = '{w0: pk(3, 3, 3, 8),       w1: pk(8, 3, 3, 3),                   e0: 18'd8,       e1: 18'd8};
        tbl[4] = '{w0: pk(0, 0, 0, 0),       w1: pk(0, 0, 0, 0),                   e0: 18'd0,       e1: 18'd0};
        tbl[5] = '{w0: pk('h3FFFF, 0, 0, 'h3FFFE), w1: pk('h20000, 'h1FFFF, 'h20001, 0),
                   e0: 18'h3FFFF, e1: 18'h20001};

        // Reset state
        #2;
        chk("rst_dout_vld",   32'(bus.dout_vld),   32'd0);
        chk("rst_dout_0",     32'(bus.dout_0),     32'd0);
        chk("rst_dout_1",     32'(bus.dout_1),     32'd0);
        chk("rst_dout_idx",   32'(bus.dout_idx),   32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_bsy",        32'(bus.bsy),        32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed vectors, applied back to back in order
        for (int i = 0; i < 6; i++)
            run_window(tbl[i].w0, tbl[i].w1, tbl[i].e0, tbl[i].e1);

        // Random windows, half with a narrow range to provoke ties
        for (int i = 0; i < 40; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (i % 2 == 0) begin
                    a[j] = DW'($urandom_range(0, (1 << DW) - 1));
                    b[j] = DW'($urandom_range(0, (1 << DW) - 1));
                end else begin
                    a[j] = DW'($urandom_range(0, 3));
                    b[j] = DW'($urandom_range(0, 3));
                end
            end
            run_window(a, b, ref_max(a), ref_max(b));
        end

        // Reset asserted mid-window (state C2)
        bus.rdy_in = 1'b1;
        @(posedge clk);
        #1 bus.rdy_in = 1'b0;
        bus.din_0 = 18'd77;
        bus.din_1 = 18'd66;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_dout_vld", 32'(bus.dout_vld), 32'd0);
        chk("arst_dout_0",   32'(bus.dout_0),   32'd0);
        chk("arst_dout_1",   32'(bus.dout_1),   32'd0);
        chk("arst_dout_idx", 32'(bus.dout_idx), 32'd0);
        chk("arst_bsy",      32'(bus.bsy),      32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        exp_idx = 0;
        @(negedge clk);
        run_window(pk(11, 12, 13, 10), pk(2, 1, 2, 1), 18'd13, 18'd2);

        // Full frame with rdy_in held high against a RAM model
        pulse_tx_done();
        for (int k = 0; k < int'(N_WIN); k++)
            for (int j = 0; j < 4; j++) begin
                m0[k][j] = DW'($urandom_range(0, (1 << DW) - 1));
                m1[k][j] = DW'($urandom_range(0, (1 << DW) - 1));
            end
        vld_cnt = 0;
        fd_cnt  = 0;
        mon_en  = 1;
        bus.rdy_in = 1'b1;
        for (int k = 0; k < int'(N_WIN); k++) begin
            for (int j = 0; j < 4; j++) begin
                @(posedge clk);
                #1;
                a[j] = m0[k][j];
                b[j] = m1[k][j];
                bus.din_0 = a[j];
                bus.din_1 = b[j];
            end
            @(posedge clk);
            @(negedge clk);
            chk("stream_vld",   32'(bus.dout_vld),   32'd1);
            chk("stream_d0",    32'(bus.dout_0),     32'(ref_max(a)));
            chk("stream_d1",    32'(bus.dout_1),     32'(ref_max(b)));
            chk("stream_idx",   32'(bus.dout_idx),   32'(k));
            chk("stream_fdone", 32'(bus.frame_done), 32'(k == int'(N_WIN) - 1));
        end
        repeat (20) @(negedge clk);
        chk("stream_vld_count", 32'(vld_cnt), 32'(N_WIN));
        chk("stream_fd_count",  32'(fd_cnt),  32'd1);
        chk("done_bsy",         32'(bus.bsy), 32'd0);
        mon_en     = 0;
        bus.rdy_in = 1'b0;

        // Leave DONE with tx_done, then abort window 4 in C1
        pulse_tx_done();
        for (int i = 0; i < 4; i++)
            run_window(pk(i + 1, 0, 0, 0), pk(0, 0, 0, i + 2), DW'(i + 1), DW'(i + 2));
        bus.rdy_in = 1'b1;
        @(posedge clk);
        #1 bus.rdy_in = 1'b0;
        bus.din_0 = 18'd500;
        bus.din_1 = 18'd500;
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.dout_vld) nv++;
        end
        chk("abort_no_vld",   32'(nv),           32'd0);
        chk("abort_idx_hold", 32'(bus.dout_idx), 32'd3);
        chk("abort_d0_hold",  32'(bus.dout_0),   32'(last0));
        exp_idx = 0;

        // tx_done together with rdy_in in IDLE: not accepted
        tx_done    = 1'b1;
        bus.rdy_in = 1'b1;
        @(posedge clk);
        #1;
        tx_done    = 1'b0;
        bus.rdy_in = 1'b0;
        @(negedge clk);
        chk("txd_rdy_bsy", 32'(bus.bsy), 32'd0);
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.dout_vld) nv++;
        end
        chk("txd_rdy_no_vld", 32'(nv), 32'd0);
        run_window(pk(9, 8, 7, 6), pk(1, 2, 3, 4), 18'd9, 18'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_0_pool.md
Name: layer_0_pool

Overview:
- Consumer end of the layer-0 pooling read port: 2x2 max-pool stage that takes the layer-0 feature RAM outputs (two 18-bit channels) plus layer-0 `rdy`, and emits one pooled value per channel per window.
- Mirrors the layer-0 read sequencer timing exactly: one window = 5 cycles, four RAM words arriving on the four cycles after `rdy` is accepted.
- Produces a 169-entry (13x13) pooled stream with index and frame-done for the next layer.

Parameters:
- DW, 18, data width per channel (layer-0 post-ReLU words, non-negative).
- N_WIN, 169, pooled windows per frame.
- IW, 8, width of `dout_idx`.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_done  input  1  frame abort/restart strobe, synchronous; shared with layer_0.
- rdy_in  input  1  layer-0 `rdy`: at least one full window is written and readable.
- din_0  input  DW  layer-0 RAM channel 0 read data (1-cycle synchronous read).
- din_1  input  DW  layer-0 RAM channel 1 read data.
- dout_vld  output  1  one-cycle pulse: `dout_0`/`dout_1`/`dout_idx` hold a new pooled result.
- dout_0  output  DW  pooled max, channel 0.
- dout_1  output  DW  pooled max, channel 1.
- dout_idx  output  IW  window index 0..N_WIN-1, row-major 13x13.
- frame_done  output  1  one-cycle pulse coincident with `dout_vld` for window N_WIN-1.
- bsy  output  1  high while in C0..C3.

Behaviour:
- Reset values (async, `rst_n` low): state IDLE; `dout_vld`=0, `dout_0`=0, `dout_1`=0, `dout_idx`=0, `frame_done`=0, `bsy`=0; running-max registers 0; window counter 0.
- States and transitions:
  - IDLE → C0 when `rdy_in`=1.
  - C0 → C1 → C2 → C3 unconditionally.
  - C3 → IDLE, or C3 → DONE if this was window N_WIN-1.
  - DONE holds until `tx_done`.
- Cycle timing: `rdy_in` sampled high in IDLE at cycle t (layer-0 issues window word 0 address at t).
  - `din_*` carries window words 0, 1, 2, 3 in cycles t+1..t+4, i.e. states C0..C3.
- Datapath:
  - In C0, max0 := `din_0` and max1 := `din_1` (no compare against stale value).
  - In C1 and C2, max := (din > max) ? din : max.
  - In C3, `dout_x` := max(max_x, `din_x`), registered.
  - Compare is unsigned DW-bit; equal values keep the held value.
- Output: `dout_vld`=1 in cycle t+5 only. `dout_0`/`dout_1`/`dout_idx` hold their value until the next result; `dout_idx` is the index of the result shown.
- Latency: 5 cycles from `rdy_in` accept to `dout_vld`. Back-to-back: `rdy_in` high again at t+5 (state IDLE) is accepted, giving one result every 5 cycles sustained.
- `rdy_in` is ignored in C0..C3 and DONE.
- Window counter:
  - Increments on each C3.
  - On window N_WIN-1 (counter = 168), `frame_done` pulses with `dout_vld`, the counter returns to 0, and the state goes to DONE.
  - In DONE, `rdy_in` is ignored.
- `tx_done` (synchronous, highest priority after reset):
  - State → IDLE; counter 0; max registers 0; `dout_vld` and `frame_done` forced 0 the next cycle.
  - `dout_0`/`dout_1`/`dout_idx` keep their last value.
  - `tx_done` mid-window (C0..C3) aborts the window with no output.
  - `tx_done` together with `rdy_in` in IDLE: `tx_done` wins and the window is not accepted.
- No back-pressure exists. The downstream must accept every `dout_vld` pulse.

Test Plan:
- Reset: `rst_n` low mid-window (state C2) → all outputs 0 immediately, state IDLE; after release, first result has `dout_idx`=0.
- Single window: `rdy_in` pulse at t, then `din_0`=5,9,3,7 and `din_1`=0,0,0x3FFFF,1 in t+1..t+4 → at t+5 `dout_vld`=1, `dout_0`=9, `dout_1`=0x3FFFF, `dout_idx`=0; `dout_vld`=0 at t+6.
- Ordering/C0 load: previous window max 100, next window words 1,2,3,4 → result 4, which proves C0 overwrites instead of comparing. Max in last word (3,3,3,8) → 8; all equal 0 → 0.
- Throughput: `rdy_in` held high for 169x5 cycles with a layer_0 RAM model → `dout_vld` every 5 cycles, `dout_idx` 0..168. `frame_done` only with idx 168, then DONE; further `rdy_in` yields no `dout_vld`.
- tx_done abort: `tx_done` in C1 of window 4 → no `dout_vld` for that window, next accepted window reports idx 0. `tx_done`+`rdy_in` same cycle in IDLE → not accepted.
- Integration: layer_0 + layer_0_pool with a 28x28 binary image and known weights → all 169 pooled values match the golden model for both channels.
